// File: rtl/message_mode_tx.sv
// Repeating UART 8N1 transmitter for a fixed "HELLO\r\n" message.
// Ports: clk, rst (async, active-low), SW, txd, word, counter, transmit_ready.
module message_mode_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MSG_LEN      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SW,
  output logic       txd,
  output logic [7:0] word,
  output logic [9:0] counter,
  output logic       transmit_ready
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [9:0] CMAX = 10'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST = 3'(MSG_LEN - 1);

  state_t     state, state_d;
  logic [9:0] counter_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [2:0] char_idx, char_idx_d;
  logic [7:0] word_d;
  logic       txd_d;
  logic       ready_d;
  logic       bit_end;

  function automatic logic [7:0] rom(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h48;
      3'd1:    c = 8'h45;
      3'd2:    c = 8'h4C;
      3'd3:    c = 8'h4C;
      3'd4:    c = 8'h4F;
      3'd5:    c = 8'h0D;
      3'd6:    c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state;
    counter_d  = counter;
    bit_idx_d  = bit_idx;
    char_idx_d = char_idx;
    word_d     = word;
    bit_end    = (counter == CMAX);

    case (state)
      IDLE: begin
        counter_d  = '0;
        char_idx_d = '0;
        bit_idx_d  = '0;
        if (SW) begin
          state_d = START;
          word_d  = rom(3'd0);
        end
      end
      START: begin
        counter_d = bit_end ? 10'd0 : counter + 10'd1;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        counter_d = bit_end ? 10'd0 : counter + 10'd1;
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        counter_d = bit_end ? 10'd0 : counter + 10'd1;
        if (bit_end) begin
          if (char_idx == LAST) begin
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx + 3'd1;
            word_d     = rom(char_idx + 3'd1);
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output regs follow the next state so txd lines up with the state.
    txd_d = 1'b1;
    unique case (1'b1)
      state_d == START: txd_d = 1'b0;
      state_d == DATA:  txd_d = word_d[bit_idx_d];
      default:          txd_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      counter        <= '0;
      bit_idx        <= '0;
      char_idx       <= '0;
      word           <= 8'h00;
      txd            <= 1'b1;
      transmit_ready <= 1'b1;
    end else begin
      state          <= state_d;
      counter        <= counter_d;
      bit_idx        <= bit_idx_d;
      char_idx       <= char_idx_d;
      word           <= word_d;
      txd            <= txd_d;
      transmit_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_message_mode_tx.sv
// Scoreboard bench: message-level model feeds expected bytes,
// a UART decoder on txd pops and compares.
module tb_message_mode_tx;

  logic       clk;
  logic       rst;
  logic       sw;
  logic       txd;
  logic [7:0] word;
  logic [9:0] counter;
  logic       ready;

  logic       rst2;
  logic       sw2;
  logic       txd2;
  logic [7:0] word2;
  logic [9:0] counter2;
  logic       ready2;

  int checks = 0;
  int failures = 0;
  int cmax1 = 0;
  int cmax2 = 0;

  logic [7:0] msg [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C,
                          8'h4F, 8'h0D, 8'h0A};
  logic [7:0] exp_q [$];

  // Message period in cycles: 7 frames of 40 cycles plus one idle cycle.
  localparam int PERIOD = 281;

  message_mode_tx #(.CLKS_PER_BIT(4), .MSG_LEN(7)) dut (
    .clk(clk),
    .rst(rst),
    .SW(sw),
    .txd(txd),
    .word(word),
    .counter(counter),
    .transmit_ready(ready)
  );

  message_mode_tx #(.CLKS_PER_BIT(868), .MSG_LEN(7)) dut2 (
    .clk(clk),
    .rst(rst2),
    .SW(sw2),
    .txd(txd2),
    .word(word2),
    .counter(counter2),
    .transmit_ready(ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (int'(counter) > cmax1) cmax1 = int'(counter);
      if (int'(counter2) > cmax2) cmax2 = int'(counter2);
    end
  end

  // UART receiver: samples txd on falling clock edges, 4 samples per bit,
  // taking the 2nd sample of each bit as the mid-bit value.
  initial begin
    int ph;
    logic [7:0] sh;
    logic [7:0] e;
    ph = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ph = 0;
      end else if (ph == 0) begin
        if (!txd) ph = 1;
      end else begin
        ph++;
        if (ph == 2) begin
          chk("start_bit", int'(txd), 0);
          chk("ready_busy", int'(ready), 0);
          if (exp_q.size() > 0)
            chk("word_out", int'(word), int'(exp_q[0]));
          sh = '0;
        end else if (ph > 2 && ph < 38 && (ph - 2) % 4 == 0) begin
          sh = {txd, sh[7:1]};
        end else if (ph == 38) begin
          chk("stop_bit", int'(txd), 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(sh), -1);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", int'(sh), int'(e));
          end
          ph = 0;
        end
      end
    end
  end

  // Hold SW high for d edges starting with the next IDLE sample edge.
  // A message starts at every edge 281*k that sees SW=1.
  task automatic run_msgs(input int d, input bit first);
    int msgs;
    int t;
    @(negedge clk);
    rst = 1'b1;
    sw  = 1'b1;
    msgs = (d - 1) / PERIOD + 1;
    for (int m = 0; m < msgs; m++)
      for (int c = 0; c < 7; c++)
        exp_q.push_back(msg[c]);
    @(posedge clk);
    #1;
    if (first) begin
      chk("first_ready", int'(ready), 0);
      chk("first_word", int'(word), 8'h48);
      chk("first_txd", int'(txd), 0);
    end
    repeat (d - 1) @(posedge clk);
    #1 sw = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (400) @(negedge clk);
    chk("idle_ready", int'(ready), 1);
    chk("idle_txd", int'(txd), 1);
    chk("idle_word", int'(word), 8'h0A);
    chk("idle_counter", int'(counter), 0);
  endtask

  initial begin
    int n;
    rst  = 1'b0;
    sw   = 1'b1;
    rst2 = 1'b0;
    sw2  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_ready", int'(ready), 1);
    chk("rst_counter", int'(counter), 0);
    chk("rst_word", int'(word), 0);

    run_msgs(600 + int'($urandom_range(0, 200)), 1'b1);
    for (int r = 0; r < 3; r++)
      run_msgs(int'($urandom_range(1, 700)), 1'b0);
    // Drop during char 3 (cycles 120..159 of the message).
    run_msgs(121 + int'($urandom_range(0, 38)), 1'b0);

    // Reset during DATA of char 2 (cycles 84..115 after start edge).
    @(negedge clk);
    sw = 1'b1;
    for (int c = 0; c < 7; c++) exp_q.push_back(msg[c]);
    repeat (88 + int'($urandom_range(0, 24))) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_txd", int'(txd), 1);
    chk("async_ready", int'(ready), 1);
    chk("async_counter", int'(counter), 0);
    chk("async_pending", exp_q.size(), 5);
    exp_q.delete();
    repeat (3) @(negedge clk);
    run_msgs(int'($urandom_range(1, 300)), 1'b1);

    // Full-rate timing on the 868-cycle instance.
    @(negedge clk);
    rst2 = 1'b1;
    sw2  = 1'b1;
    n = 0;
    while (txd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("slow_start_seen", int'(txd2), 0);
    sw2 = 1'b0;
    n = 0;
    while (!txd2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("slow_low_run", n, 4 * 868);
    n = 0;
    while (txd2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("slow_high_run", n, 868);

    chk("counter_max4", cmax1, 3);
    chk("counter_max868", cmax2, 867);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
